// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan scheduler: time-shares one hex decoder between
// both digits, inserts dark gaps between digits and snapshots both values per frame.
module seg_scan_ctrl #(
   parameter int DWELL_CYC = 24000,
   parameter int BLANK_CYC = 240,
   parameter int CNT_W     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] dig0_val,
   input  logic [3:0] dig1_val,
   output logic [3:0] nib_out,
   output logic       sel,
   output logic [1:0] an_n,
   output logic       frame_tick
);

   typedef enum logic [2:0] {IDLE, SHOW0, GAP0, SHOW1, GAP1} state_t;

   localparam bit             HAS_GAP    = (BLANK_CYC > 0);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = HAS_GAP ? CNT_W'(BLANK_CYC - 1) : '0;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       shadow0;
   logic [3:0]       shadow1;

   // NOTE: every register here is state, so all assignments are non-blocking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shadow0    <= 4'h0;
         shadow1    <= 4'h0;
         nib_out    <= 4'h0;
         sel        <= 1'b0;
         an_n       <= 2'b11;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         cnt        <= cnt + CNT_W'(1);
         if (state != IDLE && !en) begin
            // Abandon the partial frame; shadows keep their last snapshot.
            state <= IDLE;
            cnt   <= '0;
            an_n  <= 2'b11;
            sel   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (en) begin
                     shadow0 <= dig0_val;
                     shadow1 <= dig1_val;
                     nib_out <= dig0_val;
                     sel     <= 1'b0;
                     if (HAS_GAP) begin
                        state <= GAP1;
                        an_n  <= 2'b11;
                     end else begin
                        state      <= SHOW0;
                        an_n       <= 2'b10;
                        frame_tick <= 1'b1;
                     end
                  end
               end
               SHOW0: begin
                  if (cnt == DWELL_LAST) begin
                     cnt     <= '0;
                     sel     <= 1'b1;
                     nib_out <= shadow1;
                     if (HAS_GAP) begin
                        state <= GAP0;
                        an_n  <= 2'b11;
                     end else begin
                        state <= SHOW1;
                        an_n  <= 2'b01;
                     end
                  end
               end
               GAP0: begin
                  if (cnt == BLANK_LAST) begin
                     cnt   <= '0;
                     state <= SHOW1;
                     an_n  <= 2'b01;
                  end
               end
               SHOW1: begin
                  if (cnt == DWELL_LAST) begin
                     // Frame boundary: take a fresh, untorn pair of digit values.
                     cnt     <= '0;
                     shadow0 <= dig0_val;
                     shadow1 <= dig1_val;
                     nib_out <= dig0_val;
                     sel     <= 1'b0;
                     if (HAS_GAP) begin
                        state <= GAP1;
                        an_n  <= 2'b11;
                     end else begin
                        state      <= SHOW0;
                        an_n       <= 2'b10;
                        frame_tick <= 1'b1;
                     end
                  end
               end
               GAP1: begin
                  if (cnt == BLANK_LAST) begin
                     cnt        <= '0;
                     state      <= SHOW0;
                     an_n       <= 2'b10;
                     frame_tick <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  an_n  <= 2'b11;
                  sel   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a gapped build and a gapless build share
// stimulus; a frame-position model predicts each cycle's outputs.
module tb_seg_scan_ctrl;

   localparam int DW = 4;

   typedef struct packed {
      logic [1:0] an;
      logic       sel;
      logic [3:0] nib;
      logic       tick;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic [3:0] d0;
   logic [3:0] d1;

   logic [3:0] nib_a, nib_b;
   logic       sel_a, sel_b;
   logic [1:0] an_a, an_b;
   logic       tick_a, tick_b;

   int total = 0;
   int bad   = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Model: position t inside a frame that starts at the snapshot cycle.
   int         bl[2] = '{2, 0};
   bit         running[2];
   int         t[2];
   logic [3:0] s0[2];
   logic [3:0] s1[2];
   logic [3:0] last_nib[2];

   seg_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(2), .CNT_W(8)) dut_gap (
      .clk(clk), .reset(reset), .en(en), .dig0_val(d0), .dig1_val(d1),
      .nib_out(nib_a), .sel(sel_a), .an_n(an_a), .frame_tick(tick_a)
   );

   seg_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(0), .CNT_W(8)) dut_nogap (
      .clk(clk), .reset(reset), .en(en), .dig0_val(d0), .dig1_val(d1),
      .nib_out(nib_b), .sel(sel_b), .an_n(an_b), .frame_tick(tick_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_step(input int k);
      int   f;
      bit   second;
      exp_t e;
      f = 2 * (DW + bl[k]);
      if (reset) begin
         running[k]  = 1'b0;
         s0[k]       = 4'h0;
         s1[k]       = 4'h0;
         last_nib[k] = 4'h0;
      end else if (!running[k]) begin
         if (en) begin
            running[k] = 1'b1;
            t[k]       = 0;
            s0[k]      = d0;
            s1[k]      = d1;
         end
      end else if (!en) begin
         running[k] = 1'b0;
      end else begin
         t[k] = t[k] + 1;
         if (t[k] == f) begin
            t[k]  = 0;
            s0[k] = d0;
            s1[k] = d1;
         end
      end
      if (running[k]) begin
         second = (t[k] >= bl[k] + DW);
         e.nib  = second ? s1[k] : s0[k];
         e.sel  = second;
         e.an[0] = !(t[k] >= bl[k] && t[k] < bl[k] + DW);
         e.an[1] = !(t[k] >= 2 * bl[k] + DW);
         e.tick = (t[k] == bl[k]);
      end else begin
         e.an   = 2'b11;
         e.sel  = 1'b0;
         e.nib  = last_nib[k];
         e.tick = 1'b0;
      end
      last_nib[k] = e.nib;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Drive one cycle of inputs, then predict what that edge produced.
   task automatic cycle(input logic e, input logic [3:0] a, input logic [3:0] b);
      en = e;
      d0 = a;
      d1 = b;
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
   endtask

   task automatic run_until(input int target, input logic [3:0] a, input logic [3:0] b);
      int n;
      n = 0;
      while (t[0] != target && n < 40) begin
         cycle(1'b1, a, b);
         n++;
      end
      check("reach_phase", 32'(t[0] == target && running[0]), 32'd1);
   endtask

   // Monitor: compares DUT outputs against queued predictions on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("gap_an",   32'(an_a),   32'(e.an));
            check("gap_sel",  32'(sel_a),  32'(e.sel));
            check("gap_nib",  32'(nib_a),  32'(e.nib));
            check("gap_tick", 32'(tick_a), 32'(e.tick));
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("nogap_an",   32'(an_b),   32'(e.an));
            check("nogap_sel",  32'(sel_b),  32'(e.sel));
            check("nogap_nib",  32'(nib_b),  32'(e.nib));
            check("nogap_tick", 32'(tick_b), 32'(e.tick));
         end
         check("gap_an_not_00",   32'(an_a != 2'b00), 32'd1);
         check("nogap_an_not_00", 32'(an_b != 2'b00), 32'd1);
      end
   end

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      d0    = 4'h0;
      d1    = 4'h0;

      // Held in reset with the display disabled.
      for (int i = 0; i < 20; i++) cycle(1'b0, 4'h0, 4'h0);
      reset = 1'b0;

      // Steady scanning of 3/A for three gapped frames.
      for (int i = 0; i < 36; i++) cycle(1'b1, 4'h3, 4'hA);

      // dig0 changes mid-SHOW0; must not appear until the next snapshot.
      run_until(3, 4'h3, 4'hA);
      for (int i = 0; i < 24; i++) cycle(1'b1, 4'h7, 4'hA);

      // Enable dropped in the second SHOW1 cycle, then re-enabled.
      run_until(2 * 2 + DW, 4'h7, 4'hA);
      cycle(1'b1, 4'h7, 4'hA);
      for (int i = 0; i < 5; i++) cycle(1'b0, 4'h5, 4'h6);
      for (int i = 0; i < 14; i++) cycle(1'b1, 4'h5, 4'h6);

      // Asynchronous reset raised between edges in the middle of SHOW1.
      run_until(2 * 2 + DW + 1, 4'h5, 4'h6);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_gap_an",    32'(an_a),  32'h3);
      check("async_gap_nib",   32'(nib_a), 32'h0);
      check("async_nogap_an",  32'(an_b),  32'h3);
      check("async_nogap_sel", 32'(sel_b), 32'h0);
      cycle(1'b1, 4'h9, 4'h2);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) cycle(1'b1, 4'h9, 4'h2);

      // Randomized digits with occasional enable drops.
      for (int i = 0; i < 900; i++)
         cycle(($urandom_range(0, 59) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      @(negedge clk);
      #1;
      check("gap_queue_drained",   32'(q0.size()), 32'd0);
      check("nogap_queue_drained", 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
